// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: retirement-trace recorder. Tags up to NCH in-order
// commit lanes per cycle with sequential instruction numbers and queues them
// in a DEPTH-entry FIFO that is drained through a valid/ready port. It also
// keeps the instruction, cycle and drop counters and tracks halt.
module commit_trace_buffer #(
    parameter  int DATA_W  = 16,
    parameter  int REG_W   = 3,
    parameter  int NCH     = 2,
    parameter  int DEPTH   = 16,
    parameter  int CNT_W   = 32,
    localparam int ENTRY_W = CNT_W + 5*DATA_W + REG_W + 5,
    localparam int OCC_W   = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH-1:0]        cm_valid,
    input  logic [NCH*DATA_W-1:0] cm_pc,
    input  logic [NCH*DATA_W-1:0] cm_inst,
    input  logic [NCH*DATA_W-1:0] cm_wdata,
    input  logic [NCH*DATA_W-1:0] cm_maddr,
    input  logic [NCH*DATA_W-1:0] cm_mdata,
    input  logic [NCH*REG_W-1:0]  cm_wreg,
    input  logic [NCH-1:0]        cm_regwrite,
    input  logic [NCH-1:0]        cm_memread,
    input  logic [NCH-1:0]        cm_memwrite,
    input  logic [NCH-1:0]        cm_halt,
    output logic                  tr_valid,
    input  logic                  tr_ready,
    output logic [ENTRY_W-1:0]    tr_data,
    output logic [CNT_W-1:0]      inst_count,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      drop_count,
    output logic [OCC_W-1:0]      occupancy,
    output logic                  overflow,
    output logic                  halted,
    output logic                  done
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [OCC_W-1:0]   occ_q;
    logic [CNT_W-1:0]   inst_q;
    logic [CNT_W-1:0]   cycle_q;
    logic [CNT_W-1:0]   drop_q;
    logic               overflow_q;
    logic               halted_q;
    logic               done_q;
    logic               valid_q;
    logic               pend_q;

    logic [NCH-1:0]     push_en_d;
    logic [PTR_W-1:0]   push_idx_d   [NCH];
    logic [ENTRY_W-1:0] push_entry_d [NCH];
    logic [OCC_W-1:0]   push_cnt_d;
    logic [OCC_W-1:0]   act_cnt_d;
    logic [OCC_W-1:0]   drop_cnt_d;
    logic [OCC_W-1:0]   free_d;
    logic [OCC_W-1:0]   occ_d;
    logic               stop_d;
    logic               halt_hit_d;
    logic               pend_d;
    logic               pop_d;

    assign tr_valid    = valid_q;
    assign tr_data     = mem_q[rd_ptr_q];
    assign inst_count  = inst_q;
    assign cycle_count = cycle_q;
    assign drop_count  = drop_q;
    assign occupancy   = occ_q;
    assign overflow    = overflow_q;
    assign halted      = halted_q;
    assign done        = done_q;

    // Rank active lanes in lane order; fill free slots first, drop the rest.
    always_comb begin
        stop_d     = 1'b0;
        halt_hit_d = 1'b0;
        act_cnt_d  = '0;
        push_cnt_d = '0;
        drop_cnt_d = '0;
        pend_d     = pend_q;
        free_d     = OCC_W'(DEPTH) - occ_q;
        for (int i = 0; i < NCH; i++) begin
            push_en_d[i]    = 1'b0;
            push_idx_d[i]   = '0;
            push_entry_d[i] = '0;
            if (!halted_q && !stop_d && cm_valid[i]) begin
                if (cm_halt[i]) begin
                    halt_hit_d = 1'b1;
                    stop_d     = 1'b1;
                end else begin
                    stop_d     = 1'b0;
                end
                if (act_cnt_d < free_d) begin
                    push_en_d[i]    = 1'b1;
                    push_idx_d[i]   = wr_ptr_q + PTR_W'(push_cnt_d);
                    push_entry_d[i] = {inst_q + CNT_W'(act_cnt_d),
                                       cm_pc[i*DATA_W +: DATA_W],
                                       cm_inst[i*DATA_W +: DATA_W],
                                       cm_wdata[i*DATA_W +: DATA_W],
                                       cm_maddr[i*DATA_W +: DATA_W],
                                       cm_mdata[i*DATA_W +: DATA_W],
                                       cm_wreg[i*REG_W +: REG_W],
                                       cm_regwrite[i], cm_memread[i],
                                       cm_memwrite[i], cm_halt[i], pend_d};
                    pend_d          = 1'b0;
                    push_cnt_d      = push_cnt_d + OCC_W'(1);
                end else begin
                    pend_d          = 1'b1;
                    drop_cnt_d      = drop_cnt_d + OCC_W'(1);
                end
                act_cnt_d = act_cnt_d + OCC_W'(1);
            end else begin
                stop_d = stop_d;
            end
        end
        pop_d = valid_q & tr_ready;
        occ_d = occ_q + push_cnt_d - OCC_W'(pop_d);
    end

    // FIFO storage: one write port per lane into distinct consecutive slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push_en_d[i]) begin
                    mem_q[push_idx_d[i]] <= push_entry_d[i];
                end
            end
        end
    end

    // Pointers, occupancy, counters and sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            inst_q     <= '0;
            cycle_q    <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
            halted_q   <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_q + PTR_W'(push_cnt_d);
            rd_ptr_q   <= rd_ptr_q + PTR_W'(pop_d);
            occ_q      <= occ_d;
            inst_q     <= inst_q + CNT_W'(act_cnt_d);
            drop_q     <= drop_q + CNT_W'(drop_cnt_d);
            overflow_q <= overflow_q | (drop_cnt_d != '0);
            halted_q   <= halted_q | halt_hit_d;
            done_q     <= (halted_q | halt_hit_d) & (occ_d == '0);
            valid_q    <= (occ_d != '0);
            pend_q     <= pend_d;
            if (!halted_q) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end else begin
                cycle_q <= cycle_q;
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: a stimulus process drives commit
// lanes and a lane-list reference model; a monitor compares each popped entry.
module tb_commit_trace_buffer;

    localparam int DATA_W  = 16;
    localparam int REG_W   = 3;
    localparam int NCH     = 2;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = 32;
    localparam int ENTRY_W = CNT_W + 5*DATA_W + REG_W + 5;
    localparam int OCC_W   = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NCH-1:0]        cm_valid, cm_regwrite, cm_memread, cm_memwrite, cm_halt;
    logic [NCH*DATA_W-1:0] cm_pc, cm_inst, cm_wdata, cm_maddr, cm_mdata;
    logic [NCH*REG_W-1:0]  cm_wreg;
    logic                  tr_valid, tr_ready;
    logic [ENTRY_W-1:0]    tr_data;
    logic [CNT_W-1:0]      inst_count, cycle_count, drop_count;
    logic [OCC_W-1:0]      occupancy;
    logic                  overflow, halted, done;

    commit_trace_buffer #(.DATA_W(DATA_W), .REG_W(REG_W), .NCH(NCH),
                          .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cm_valid(cm_valid), .cm_pc(cm_pc),
        .cm_inst(cm_inst), .cm_wdata(cm_wdata), .cm_maddr(cm_maddr),
        .cm_mdata(cm_mdata), .cm_wreg(cm_wreg), .cm_regwrite(cm_regwrite),
        .cm_memread(cm_memread), .cm_memwrite(cm_memwrite), .cm_halt(cm_halt),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_data(tr_data),
        .inst_count(inst_count), .cycle_count(cycle_count),
        .drop_count(drop_count), .occupancy(occupancy), .overflow(overflow),
        .halted(halted), .done(done));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [ENTRY_W-1:0] exp_q[$];
    logic [CNT_W-1:0]   m_inst, m_cycle, m_drop;
    int                 m_occ;
    bit                 m_ovf, m_halted, m_pend;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_inst = '0; m_cycle = '0; m_drop = '0;
        m_occ = 0; m_ovf = 0; m_halted = 0; m_pend = 0;
    endtask

    // One clock: drive lanes, predict the edge's effect, then check counters.
    task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] h,
                        input logic rdy, input logic [DATA_W-1:0] pc0);
        int act[$];
        int li, freec, pushed;
        bit hit;
        logic [ENTRY_W-1:0] e;
        cm_valid = v; cm_halt = h; tr_ready = rdy;
        for (int i = 0; i < NCH; i++) begin
            cm_pc[i*DATA_W +: DATA_W]    = pc0 + DATA_W'(2*i);
            cm_inst[i*DATA_W +: DATA_W]  = DATA_W'($urandom);
            cm_wdata[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            cm_maddr[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            cm_mdata[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            cm_wreg[i*REG_W +: REG_W]    = REG_W'($urandom);
            cm_regwrite[i] = 1'($urandom);
            cm_memread[i]  = 1'($urandom);
            cm_memwrite[i] = 1'($urandom);
        end
        pushed = 0;
        if (!m_halted) begin
            hit = 0;
            for (int i = 0; i < NCH && !hit; i++) begin
                if (v[i]) begin
                    act.push_back(i);
                    if (h[i]) hit = 1;
                end
            end
            freec = DEPTH - m_occ;
            for (int k = 0; k < act.size(); k++) begin
                li = act[k];
                if (k < freec) begin
                    e = {m_inst + CNT_W'(k), cm_pc[li*DATA_W +: DATA_W],
                         cm_inst[li*DATA_W +: DATA_W], cm_wdata[li*DATA_W +: DATA_W],
                         cm_maddr[li*DATA_W +: DATA_W], cm_mdata[li*DATA_W +: DATA_W],
                         cm_wreg[li*REG_W +: REG_W], cm_regwrite[li], cm_memread[li],
                         cm_memwrite[li], h[li], m_pend};
                    exp_q.push_back(e);
                    m_pend = 0;
                    pushed++;
                end else begin
                    m_drop = m_drop + CNT_W'(1);
                    m_pend = 1;
                    m_ovf  = 1;
                end
            end
            m_inst  = m_inst + CNT_W'(act.size());
            m_cycle = m_cycle + CNT_W'(1);
            if (hit) m_halted = 1;
        end
        m_occ = m_occ + pushed - ((m_occ > 0 && rdy) ? 1 : 0);
        @(posedge clk);
        #1;
        chk("inst_count", 128'(inst_count), 128'(m_inst));
        chk("cycle_count", 128'(cycle_count), 128'(m_cycle));
        chk("drop_count", 128'(drop_count), 128'(m_drop));
        chk("occupancy", 128'(occupancy), 128'(m_occ));
        chk("tr_valid", 128'(tr_valid), 128'(m_occ != 0));
        chk("overflow", 128'(overflow), 128'(m_ovf));
        chk("halted", 128'(halted), 128'(m_halted));
        chk("done", 128'(done), 128'(m_halted && m_occ == 0));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_tr_valid"}, 128'(tr_valid), 128'(0));
        chk({tag, "_tr_data"}, 128'(tr_data), 128'(0));
        chk({tag, "_inst"}, 128'(inst_count), 128'(0));
        chk({tag, "_cycle"}, 128'(cycle_count), 128'(0));
        chk({tag, "_drop"}, 128'(drop_count), 128'(0));
        chk({tag, "_occ"}, 128'(occupancy), 128'(0));
        chk({tag, "_ovf"}, 128'(overflow), 128'(0));
        chk({tag, "_halted"}, 128'(halted), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
    endtask

    // Monitor: handshake seen at negedge will complete at the next posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tr_valid === 1'b1 && tr_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 128'(tr_valid), 128'(0));
                end else begin
                    chk("tr_data", 128'(tr_data), 128'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; tr_ready = 1'b0;
        cm_valid = '0; cm_halt = '0; cm_regwrite = '0; cm_memread = '0; cm_memwrite = '0;
        cm_pc = '0; cm_inst = '0; cm_wdata = '0; cm_maddr = '0; cm_mdata = '0; cm_wreg = '0;
        model_clear();
        #3;
        chk_zero_outputs("reset");
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Single lane, three commits, consumer always ready
        step(2'b01, 2'b00, 1'b1, 16'h0000);
        step(2'b01, 2'b00, 1'b1, 16'h0002);
        step(2'b01, 2'b00, 1'b1, 16'h0004);
        chk("single_inst3", 128'(inst_count), 128'(3));
        for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 1'b1, 16'h0000);

        // Dual commit in one cycle, consumer stalled
        step(2'b11, 2'b00, 1'b0, 16'h0010);
        chk("dual_occ", 128'(occupancy), 128'(2));
        for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 1'b1, 16'h0000);

        // Overflow: 9 dual-commit cycles into an empty 16-entry FIFO
        for (int i = 0; i < 9; i++) step(2'b11, 2'b00, 1'b0, DATA_W'(16'h0100 + 4*i));
        chk("ovf_occ", 128'(occupancy), 128'(16));
        chk("ovf_flag", 128'(overflow), 128'(1));
        for (int i = 0; i < 18; i++) step(2'b00, 2'b00, 1'b1, 16'h0000);

        // Pop at full: same-cycle pop does not make room
        for (int i = 0; i < 8; i++) step(2'b11, 2'b00, 1'b0, DATA_W'(16'h0200 + 4*i));
        chk("full_occ", 128'(occupancy), 128'(16));
        step(2'b01, 2'b00, 1'b1, 16'h0300);
        chk("full_pop_occ", 128'(occupancy), 128'(15));
        step(2'b01, 2'b00, 1'b0, 16'h0302);
        for (int i = 0; i < 20; i++) step(2'b00, 2'b00, 1'b1, 16'h0000);

        // Randomized traffic, slow then fast consumer
        for (int i = 0; i < 300; i++) begin
            step(NCH'($urandom), 2'b00,
                 (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 DATA_W'($urandom));
        end
        for (int i = 0; i < 20; i++) step(2'b00, 2'b00, 1'b1, 16'h0000);

        // Asynchronous reset with five entries held
        for (int i = 0; i < 5; i++) step(2'b01, 2'b00, 1'b0, DATA_W'(16'h0400 + 2*i));
        chk("pre_reset_occ", 128'(occupancy), 128'(5));
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        model_clear();
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Halt on lane 0 with lane 1 also valid
        step(2'b01, 2'b00, 1'b0, 16'h0500);
        step(2'b11, 2'b01, 1'b0, 16'h0502);
        chk("halt_occ", 128'(occupancy), 128'(2));
        for (int i = 0; i < 4; i++) step(NCH'($urandom), NCH'($urandom), 1'b0, DATA_W'($urandom));
        for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 1'b1, 16'h0000);
        chk("halt_done", 128'(done), 128'(1));
        chk("halt_inst", 128'(inst_count), 128'(2));
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
